// File: rtl/serial_subtractor_if.sv
// -----------------------------------------------------------------------------
// serial_subtractor_if
// Operand/result bundle for serial_subtractor.
//   start      : request to begin a subtraction (master -> slave)
//   minuend    : adder result {carry, sum}, WIDTH+1 bits (master -> slave)
//   subtrahend : known addend to remove, WIDTH bits (master -> slave)
//   diff       : recovered operand, low WIDTH bits of the result (slave -> master)
//   borrow     : minuend < subtrahend (slave -> master)
//   range_err  : true difference not representable in WIDTH bits (slave -> master)
//   busy       : subtraction in progress (slave -> master)
//   done       : one-cycle pulse when results update (slave -> master)
// -----------------------------------------------------------------------------
interface serial_subtractor_if #(
  parameter int WIDTH = 4
) ();
  logic             start;
  logic [WIDTH:0]   minuend;
  logic [WIDTH-1:0] subtrahend;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             range_err;
  logic             busy;
  logic             done;

  modport master (
    output start, minuend, subtrahend,
    input  diff, borrow, range_err, busy, done
  );

  modport slave (
    input  start, minuend, subtrahend,
    output diff, borrow, range_err, busy, done
  );
endinterface

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial subtractor that removes a known addend from a {carry, sum} adder
// result, one bit per clock, LSB first.
//
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : serial_subtractor_if.slave (start/minuend/subtrahend in,
//           diff/borrow/range_err/busy/done out)
//
// Optional build macro:
//   RANGE_ERR_STICKY_EN : range_err latches high at the first erroneous result
//                         and stays high until reset.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; operands latched on the accepting edge
// SHIFT | one full-subtractor step per cycle, WIDTH+1 cycles
// DONE  | results updated on entry, done high for this one cycle
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           r_state;
  logic [WIDTH:0]   r_a;
  logic [WIDTH:0]   r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_bor;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_range_err;
  logic             r_busy;
  logic             r_done;

  logic w_a0;
  logic w_b0;
  logic w_d;
  logic w_bor_next;

  // One-bit full subtractor on the current LSBs and the registered borrow.
  assign w_a0       = r_a[0];
  assign w_b0       = r_b[0];
  assign w_d        = w_a0 ^ w_b0 ^ r_bor;
  assign w_bor_next = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_bor);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_res       <= '0;
      r_bor       <= 1'b0;
      r_cnt       <= '0;
      r_diff      <= '0;
      r_borrow    <= 1'b0;
      r_range_err <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a     <= bus.minuend;
            r_b     <= {1'b0, bus.subtrahend};
            r_res   <= '0;
            r_bor   <= 1'b0;
            r_cnt   <= CNT_W'(WIDTH);
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_res <= {w_d, r_res[WIDTH-1:1]};
          r_bor <= w_bor_next;
          if (r_cnt == '0) begin
            // Last step: w_d is result bit WIDTH, r_res already holds bits
            // WIDTH-1..0, so the visible result is taken directly from here.
            r_diff   <= r_res;
            r_borrow <= w_bor_next;
`ifdef RANGE_ERR_STICKY_EN
            r_range_err <= r_range_err | w_bor_next | w_d;
`else
            r_range_err <= w_bor_next | w_d;
`endif
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.diff      = r_diff;
  assign bus.borrow    = r_borrow;
  assign bus.range_err = r_range_err;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule
